// File: rtl/requant_out.sv
// requant_out: adds per-channel bias to conv1d accumulators, requantizes them to int8
// (Q31 multiply, rounding shift, offset, clamp), packs four bytes per word into a FIFO.
module requant_out #(
    parameter int MAX_CHANNELS = 128,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [6:0]  cmd,
    input  logic [31:0] inp0,
    input  logic [31:0] inp1,
    output logic [31:0] ret,
    input  logic [31:0] acc_in,
    input  logic        acc_valid,
    output logic        acc_ready
);
    localparam int DATA_W = 32;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CH_W   = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;
    localparam int NCH_W  = $clog2(MAX_CHANNELS + 1);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;

    // Round half toward +inf, then arithmetic shift by 31+sh.
    function automatic logic signed [DATA_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p,
        input logic [4:0]               sh
    );
        logic [5:0]               sa;
        logic signed [PROD_W-1:0] r;
        sa = 6'd30 + {1'b0, sh};
        r  = p + (64'sd1 <<< sa);
        r  = r >>> (sa + 6'd1);
        return r[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] clamp(
        input logic signed [DATA_W-1:0] z,
        input logic signed [DATA_W-1:0] lo,
        input logic signed [DATA_W-1:0] hi
    );
        if (z < lo) return lo;
        if (z > hi) return hi;
        return z;
    endfunction

    logic cmd_clr, cmd_bias, cmd_off, cmd_mult, cmd_shift, cmd_act;
    logic cmd_pop, cmd_stat, cmd_nch, cmd_flush;

    assign cmd_clr   = en && (cmd == 7'd0);
    assign cmd_bias  = en && (cmd == 7'd1);
    assign cmd_off   = en && (cmd == 7'd2);
    assign cmd_mult  = en && (cmd == 7'd3);
    assign cmd_shift = en && (cmd == 7'd4);
    assign cmd_act   = en && (cmd == 7'd5);
    assign cmd_pop   = en && (cmd == 7'd6);
    assign cmd_stat  = en && (cmd == 7'd7);
    assign cmd_nch   = en && (cmd == 7'd8);
    assign cmd_flush = en && (cmd == 7'd9);

    logic signed [DATA_W-1:0] bias_q [MAX_CHANNELS];
    logic signed [DATA_W-1:0] offset_q, mult_q, act_min_q, act_max_q;
    logic [4:0]               shift_q;
    logic [NCH_W-1:0]         num_ch_q;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     underflow_q;
    logic [DATA_W-1:0]        ret_q, ret_d;

    logic [DATA_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     fifo_empty, fifo_full, push_en, pop_en;

    logic                     accept;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign acc_ready  = (count_q < CNT_W'(FIFO_DEPTH - 2));
    assign accept     = acc_valid && acc_ready;
    assign ret        = ret_q;

    always_ff @(posedge clk) begin
        if (cmd_bias && (inp0 < 32'(MAX_CHANNELS)))
            bias_q[inp0[CH_W-1:0]] <= inp1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_q    <= '0;
            mult_q      <= 32'sh4000_0000;
            shift_q     <= '0;
            act_min_q   <= -32'sd128;
            act_max_q   <= 32'sd127;
            num_ch_q    <= NCH_W'(1);
            underflow_q <= 1'b0;
        end else begin
            if (cmd_off)   offset_q <= inp1;
            if (cmd_mult)  mult_q   <= inp1;
            if (cmd_shift) shift_q  <= inp1[4:0];
            if (cmd_act) begin
                act_min_q <= inp0;
                act_max_q <= inp1;
            end
            if (cmd_nch && (inp1 != '0) && (inp1 <= 32'(MAX_CHANNELS)))
                num_ch_q <= inp1[NCH_W-1:0];
            if (cmd_pop && fifo_empty) underflow_q <= 1'b1;
        end
    end

    always_comb begin
        ch_d = ch_q;
        if (cmd_clr) begin
            ch_d = '0;
        end else if (accept) begin
            if (NCH_W'(ch_q) + NCH_W'(1) >= num_ch_q) ch_d = '0;
            else                                      ch_d = ch_q + CH_W'(1);
        end
    end

    // ---- S1: bias add / S2: Q31 product / S3: requant + clamp ----
    logic signed [DATA_W-1:0] x_p1_q;
    logic signed [PROD_W-1:0] prod_p2_q;
    logic signed [DATA_W-1:0] y_p2, z_p2, sat_p2;
    logic [7:0]               byte_p3_q;
    logic                     vld_p1_q, vld_p2_q, vld_p3_q;

    always_comb begin
        y_p2   = round_shift(prod_p2_q, shift_q);
        z_p2   = y_p2 + offset_q;
        sat_p2 = clamp(z_p2, act_min_q, act_max_q);
    end

    always_ff @(posedge clk) begin
        x_p1_q    <= $signed(acc_in) + bias_q[ch_q];
        prod_p2_q <= PROD_W'(x_p1_q) * PROD_W'(mult_q);
        byte_p3_q <= sat_p2[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            ch_q     <= '0;
        end else begin
            vld_p1_q <= accept && !cmd_clr;
            vld_p2_q <= vld_p1_q && !cmd_clr;
            vld_p3_q <= vld_p2_q && !cmd_clr;
            ch_q     <= ch_d;
        end
    end

    // ---- S4: byte packer feeding the word FIFO ----
    logic [1:0]        pk_cnt_q, pk_cnt_d;
    logic [23:0]       pk_data_q;
    logic [DATA_W-1:0] pk_word;
    logic [2:0]        pk_fill;
    logic              byte_in, push_req;

    // Stale bytes beyond pk_cnt_q are masked so a flushed word carries zero upper bytes.
    always_comb begin
        byte_in = vld_p3_q && !cmd_clr;
        pk_word = '0;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(pk_cnt_q)) pk_word[8*k +: 8] = pk_data_q[8*k +: 8];
        end
        pk_fill = {1'b0, pk_cnt_q};
        if (byte_in) begin
            pk_word[{pk_cnt_q, 3'b000} +: 8] = byte_p3_q;
            pk_fill = pk_fill + 3'd1;
        end
        push_req = !cmd_clr && ((pk_fill == 3'd4) || (cmd_flush && (pk_fill != 3'd0)));
        pk_cnt_d = (cmd_clr || push_req) ? 2'd0 : pk_fill[1:0];
    end

    assign pop_en  = cmd_pop && !fifo_empty;
    assign push_en = push_req && (!fifo_full || pop_en);

    always_comb begin
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (cmd_clr) count_d = '0;
    end

    always_comb begin
        ret_d = ret_q;
        if (en) begin
            ret_d = '0;
            if (pop_en)
                ret_d = fifo_mem[rd_ptr_q];
            else if (cmd_stat)
                ret_d = {16'b0, 8'(count_q), 5'b0, underflow_q, fifo_full, fifo_empty};
        end
    end

    always_ff @(posedge clk) begin
        pk_data_q <= pk_word[23:0];
        if (push_en) fifo_mem[wr_ptr_q] <= pk_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pk_cnt_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ret_q    <= '0;
        end else begin
            pk_cnt_q <= pk_cnt_d;
            count_q  <= count_d;
            ret_q    <= ret_d;
            if (cmd_clr) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/requant_out.md
# requant_out

Output-side companion to the conv1d CFU accelerator. It accepts 32-bit raw accumulators one per cycle from the conv1d datapath and adds a per-channel bias. It requantizes each value to int8 using a Q31 multiplier and a rounding right shift, applies the output offset and activation clamp, and packs four bytes per 32-bit word into a FIFO. The CPU drains the FIFO through the same cmd/inp0/inp1/ret CFU command interface the rest of the accelerator uses.

## Interface
- MAX_CHANNELS, 128: bias table entries (per output channel).
- FIFO_DEPTH, 16: output word FIFO depth (power of two).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  CFU command strobe; cmd/inp0/inp1 act only when en=1.
- cmd  in  7  command code.
- inp0  in  32  address / first operand.
- inp1  in  32  value / second operand.
- ret  out  32  command result register; reset 0.
- acc_in  in  32  signed accumulator from conv1d.
- acc_valid  in  1  acc_in valid this cycle.
- acc_ready  out  1  block can accept acc_in; reset 1.

## Operation
- Commands (en=1):
  - 0: clear FIFO, packer and channel counter. Parameters and bias are kept.
  - 1: bias[inp0] <= inp1.
  - 2: output_offset <= inp1.
  - 3: multiplier <= inp1.
  - 4: shift <= inp1[4:0].
  - 5: act_min <= inp0, act_max <= inp1.
  - 6: pop; ret <= head word, or 0 if empty (sets sticky underflow).
  - 7: status; ret <= {16'b0, count[7:0], 5'b0, underflow, full, empty}.
  - 8: num_channels <= inp1 (1..MAX_CHANNELS).
  - 9: flush; push the partial packer word, unused upper bytes zero. No-op if the packer is empty.
  - Other codes: ret <= 0.
- Parameter reset values:
  - multiplier = 0x40000000, shift = 0, output_offset = 0.
  - act_min = -128, act_max = 127, num_channels = 1, underflow = 0.
  - bias contents are undefined after reset.
- Handshake: an accumulator is accepted when acc_valid && acc_ready.
  - On accept, the channel counter increments and wraps to 0 at num_channels.
  - The pipeline runs independently of en.
- Pipeline, one accept per cycle:
  - S1: x = acc_in + bias[ch] (32-bit wrap).
  - S2: p = x * multiplier (signed 64-bit).
  - S3: y = (p + (1 << (30+shift))) >>> (31+shift); z = y[31:0] + output_offset; clamp z to [act_min, act_max]; byte = z[7:0].
  - S4 packer: byte k of a word occupies bits [8k+7:8k], little-endian in arrival order. The 4th byte pushes the word.
- acc_ready = (count < FIFO_DEPTH-2). This margin guarantees that bytes still in flight never overflow the FIFO.
- Simultaneous push and pop in one cycle: both happen and count is unchanged.
- Flush in the same cycle as a 4th byte: the full word is pushed, and the flush then applies to the now-empty packer (no-op).
- Command 0 in the same cycle as an in-flight byte: the clear wins. In-flight bytes are discarded.
- Reset mid-operation empties all pipeline stages, the packer and the FIFO.

## Timing
- Accept at cycle t: the byte reaches the packer at t+3. A word completed by that byte is poppable via cmd 6 from cycle t+4.
- ret updates one cycle after the command edge and holds until the next en command.
- The status read reflects state before any same-cycle push or pop.
- Sustained throughput is 1 accumulator per cycle while acc_ready=1.
- acc_ready is registered-equivalent, a function of count only, with no combinational path from acc_valid.

## Test plan
- Basic requant:
  - Stimulus: num_channels=1, bias[0]=10, multiplier=0x40000000, shift=0, offset=-3; accept acc=90 four times.
  - Response: after t+4, status count=1; pop -> 0x2F2F2F2F.
- Rounding and clamp:
  - Stimulus: num_channels=4, bias=0; accept acc sequence 101, 1000, -1000, -3 with shift=0, mult=0x40000000, offset=0.
  - Response: bytes 51, 127, -128, -1; pop -> 0xFF807F33.
- Shift:
  - Stimulus: shift=2, mult=0x40000000, acc=100 ×4, bias=0.
  - Response: y=13 (12.5 rounds up); pop -> 0x0D0D0D0D.
- Backpressure:
  - Stimulus: hold acc_valid=1 for 100 cycles without popping.
  - Response: acc_ready falls when count=14; FIFO never exceeds 16; no lost or duplicated bytes after draining.
- Flush and underflow:
  - Stimulus: accept 2 bytes (0x05, 0x06), cmd 9, pop twice.
  - Response: first pop -> 0x00000605; second pop -> 0 with status underflow=1, empty=1.
- Reset mid-stream:
  - Stimulus: assert reset with 3 words queued and bytes in flight.
  - Response: ret=0, acc_ready=1, status empty=1, multiplier=0x40000000, act_min=-128, act_max=127.
